// File: rtl/mem_arbiter.sv
// Round-robin memory arbiter with burst locking and a registered memory strobe.
// Optional `MEM_ARB_FIXED_PRIO_EN gives requester 0 priority outside locked bursts.
module mem_arbiter #(
  parameter int NUM_SIZE  = 16,
  parameter int ADDR_W    = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_SIZE-1:0]          rsp_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [NUM_SIZE-1:0]          mem_wdata,
  input  logic [NUM_SIZE-1:0]          mem_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, lock_id, lock_id_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               win_vld_p0, accept_p0, we_p0, lock_p0;
  logic [PTR_W-1:0]   win_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [NUM_SIZE-1:0] wdata_p0;
  logic [NUM_REQ-1:0] rd_oh_p1;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: arbitration, combinational grant
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    win_vld_p0 = 1'b0;
    win_p0     = '0;
    idx        = 0;
    idx_w      = '0;
    if (state == LOCKED) begin
      win_vld_p0 = req_valid[lock_id];
      win_p0     = lock_id;
    end else begin
      // Scan from farthest to nearest so the first valid at/after ptr wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_w = PTR_W'(idx);
        if (req_valid[idx_w]) begin
          win_vld_p0 = 1'b1;
          win_p0     = idx_w;
        end
      end
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (req_valid[0]) begin
        win_vld_p0 = 1'b1;
        win_p0     = '0;
      end
`endif
    end
  end

  assign accept_p0 = rst & win_vld_p0;
  assign req_ready = accept_p0 ? (NUM_REQ'(1) << win_p0) : '0;
  assign we_p0     = req_we[win_p0];
  assign lock_p0   = req_lock[win_p0];
  assign addr_p0   = req_addr[int'(win_p0) * ADDR_W +: ADDR_W];
  assign wdata_p0  = req_wdata[int'(win_p0) * NUM_SIZE +: NUM_SIZE];

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    lock_id_nxt = lock_id;
    cnt_nxt     = cnt;
    case (state)
      LOCKED: begin
        if (accept_p0) begin
          if (!lock_p0 || (cnt + 1'b1) >= CNT_W'(BURST_MAX)) begin
            state_nxt = GRANT;
            ptr_nxt   = next_ptr(lock_id);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = (|req_valid) ? GRANT : IDLE;
          ptr_nxt   = next_ptr(lock_id);
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (accept_p0) begin
          if (lock_p0 && BURST_MAX > 1) begin
            state_nxt   = LOCKED;
            lock_id_nxt = win_p0;
            cnt_nxt     = CNT_W'(1);
          end else begin
            state_nxt = GRANT;
            ptr_nxt   = next_ptr(win_p0);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      lock_id <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      lock_id <= lock_id_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Stage p1: memory strobe; stage p2: read response
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_oh_p1  <= '0;
      rsp_valid <= '0;
    end else begin
      mem_en    <= accept_p0;
      mem_we    <= accept_p0 & we_p0;
      if (accept_p0) begin
        mem_addr  <= addr_p0;
        mem_wdata <= wdata_p0;
      end
      rd_oh_p1  <= we_p0 ? '0 : req_ready;
      rsp_valid <= rd_oh_p1;
    end
  end

  assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed grants, bursts, write/read, reset flush.
module tb_mem_arbiter;
  localparam int NS = 16, AW = 8, NR = 4, BM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR-1:0]  req_valid = '0, req_ready, req_we = '0, req_lock = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*NS-1:0] req_wdata = '0;
  logic [NR-1:0]  rsp_valid;
  logic [NS-1:0]  rsp_rdata, mem_wdata, mem_rdata = '0;
  logic           mem_en, mem_we;
  logic [AW-1:0]  mem_addr;

  mem_arbiter #(.NUM_SIZE(NS), .ADDR_W(AW), .NUM_REQ(NR), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  logic [NS-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int id; logic [NS-1:0] data; int due;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse pops one expected read
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {60'd0, rsp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", {60'd0, rsp_valid}, 64'(1) << e.id);
        check("rsp_data", {48'd0, rsp_rdata}, {48'd0, e.data});
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [NS-1:0] d);
    req_valid[id] = v;
    req_we[id]    = we;
    req_lock[id]  = lk;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*NS +: NS] = d;
  endtask

  task automatic expect_grant(input string nm, input logic [NR-1:0] exp, input logic [NS-1:0] rd);
    #1;
    check(nm, {60'd0, req_ready}, {60'd0, exp});
    for (int i = 0; i < NR; i++)
      if (exp[i] && !req_we[i]) sb.push_back('{i, rd, cyc + 2});
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    req_lock  = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [NS-1:0] rd029 [4];
  logic [NR-1:0] lock_seq [7];
  logic [NR-1:0] prio_seq [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 16'd3; mem[1] = 16'hFFFF; mem[2] = 16'hFFFC; mem[3] = 16'd1;
    rd029    = '{16'd3, 16'hFFFF, 16'hFFFC, 16'd1};
    lock_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
`ifdef MEM_ARB_FIXED_PRIO_EN
    prio_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    prio_seq = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
`endif

    // Reset with all requesters already valid
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(i), '0);
    tick(); tick();
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {48'd0, mem_wdata}, 64'd0);
    check("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {48'd0, rsp_rdata}, 64'd0);
    rst = 1'b1;

    // Four reads granted round-robin on consecutive cycles
    for (int g = 0; g < NR; g++) begin
      expect_grant("rr_grant", 4'(1 << g), rd029[g]);
      tick();
      req_valid[g] = 1'b0;
      check("rr_mem_en", {63'd0, mem_en}, 64'd1);
      check("rr_mem_addr", {56'd0, mem_addr}, 64'(g));
      check("rr_mem_we", {63'd0, mem_we}, 64'd0);
    end

    // Lone requester 3 with ptr at 0, then wrap back to 0
    set_req(3, 1'b1, 1'b0, 1'b0, 8'd3, '0);
    expect_grant("wrap_r3", 4'b1000, 16'd1);
    tick();
    check("wrap_mem_addr", {56'd0, mem_addr}, 64'd3);
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    expect_grant("wrap_r0", 4'b0001, 16'd3);
    tick();
    req_valid[0] = 1'b0;
    expect_grant("wrap_r3_again", 4'b1000, 16'd1);
    tick();
    idle(1);

    // Write then read back through requester 2
    set_req(2, 1'b1, 1'b1, 1'b0, 8'd5, 16'd7);
    expect_grant("wr_grant", 4'b0100, '0);
    tick();
    check("wr_mem_en", {63'd0, mem_en}, 64'd1);
    check("wr_mem_we", {63'd0, mem_we}, 64'd1);
    check("wr_mem_addr", {56'd0, mem_addr}, 64'd5);
    check("wr_mem_wdata", {48'd0, mem_wdata}, 64'd7);
    set_req(2, 1'b1, 1'b0, 1'b0, 8'd5, '0);
    expect_grant("rd_grant", 4'b0100, 16'd7);
    tick();
    check("rd_mem_we", {63'd0, mem_we}, 64'd0);
    check("rd_mem_addr", {56'd0, mem_addr}, 64'd5);
    idle(4);

    // Locked burst capped at BURST_MAX beats, then requester 3 gets one turn
    begin
      int b1 = 0;
      set_req(1, 1'b1, 1'b0, 1'b1, 8'd1, '0);
      for (int s = 0; s < 7; s++) begin
        expect_grant("lock_seq", lock_seq[s], lock_seq[s][1] ? 16'hFFFF : 16'd1);
        tick();
        if (s == 0) set_req(3, 1'b1, 1'b0, 1'b0, 8'd3, '0);
        if (lock_seq[s][3]) req_valid[3] = 1'b0;
        if (lock_seq[s][1]) b1++;
        if (b1 == 6) req_valid[1] = 1'b0;
      end
    end
    idle(4);

    // Requesters 0 and 2 both continuously valid
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 8'd2, '0);
    for (int s = 0; s < 6; s++) begin
      expect_grant("prio_seq", prio_seq[s], prio_seq[s][0] ? 16'd3 : 16'hFFFC);
      tick();
    end
    idle(4);

    // Read in flight when reset asserts must be discarded
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd1, '0);
    #1;
    check("flush_grant", {60'd0, req_ready}, 64'b0010);
    tick();
    rst = 1'b0;
    set_req(3, 1'b1, 1'b0, 1'b0, 8'd3, '0);
    #1;
    check("flush_ready_in_rst", {60'd0, req_ready}, 64'd0);
    tick();
    check("flush_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    check("flush_rsp_rdata", {48'd0, rsp_rdata}, 64'd0);
    check("flush_mem_en", {63'd0, mem_en}, 64'd0);
    check("flush_mem_addr", {56'd0, mem_addr}, 64'd0);
    tick();
    rst = 1'b1;
    expect_grant("post_rst_ptr0", 4'b0010, 16'hFFFF);
    tick();
    idle(5);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
